// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port VRAM between the BG fetcher, the
// sprite fetcher and the CPU. One access in flight at a time, walked through
// IDLE -> ACCESS -> RESP. During pixel transfer (mode 3 with the LCD on) the
// CPU is locked out and gets a blocked completion instead of a real access.
module vram_arbiter #(
    parameter int          ADDR_W        = 13,
    parameter logic [7:0]  BLOCKED_RDATA = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lcd_on,
    input  logic [1:0]        mode,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    output logic              bg_ack,
    output logic [7:0]        bg_rdata,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_ack,
    output logic [7:0]        spr_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_BG  = 2'd0,
        OWN_SPR = 2'd1,
        OWN_CPU = 2'd2
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic                blk_q, blk_d;
    logic                bg_ack_q, bg_ack_d;
    logic                spr_ack_q, spr_ack_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [7:0]          bg_rdata_q, bg_rdata_d;
    logic [7:0]          spr_rdata_q, spr_rdata_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;

    logic                gnt_vld_s;
    owner_t              gnt_own_s;
    logic                blk_s;
    logic                pix_xfer_s;

    assign pix_xfer_s = lcd_on & (mode == 2'd3);

    // Pick a winner among the live requests; blk_s flags a lone CPU request during pixel transfer.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_own_s = OWN_BG;
        blk_s     = 1'b0;
        if (!lcd_on) begin
            // PPU fetchers are ignored with the LCD off; only the CPU can win.
            if (cpu_req) begin
                gnt_vld_s = 1'b1;
                gnt_own_s = OWN_CPU;
            end else begin
                gnt_vld_s = 1'b0;
            end
        end else if (pix_xfer_s) begin
            if (spr_req) begin
                gnt_vld_s = 1'b1;
                gnt_own_s = OWN_SPR;
            end else if (bg_req) begin
                gnt_vld_s = 1'b1;
                gnt_own_s = OWN_BG;
            end else if (cpu_req) begin
                blk_s = 1'b1;
            end else begin
                gnt_vld_s = 1'b0;
            end
        end else begin
            if (cpu_req) begin
                gnt_vld_s = 1'b1;
                gnt_own_s = OWN_CPU;
            end else if (spr_req) begin
                gnt_vld_s = 1'b1;
                gnt_own_s = OWN_SPR;
            end else if (bg_req) begin
                gnt_vld_s = 1'b1;
                gnt_own_s = OWN_BG;
            end else begin
                gnt_vld_s = 1'b0;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        blk_d       = blk_q;
        bg_ack_d    = 1'b0;
        spr_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        bg_rdata_d  = bg_rdata_q;
        spr_rdata_d = spr_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld_s) begin
                    // Latch the winner; the strobe register makes ACCESS the strobe cycle.
                    owner_d = gnt_own_s;
                    blk_d   = 1'b0;
                    state_d = ACCESS;
                    case (gnt_own_s)
                        OWN_BG: begin
                            mem_addr_d  = bg_addr;
                            mem_wdata_d = 8'h00;
                            we_d        = 1'b0;
                        end
                        OWN_SPR: begin
                            mem_addr_d  = spr_addr;
                            mem_wdata_d = 8'h00;
                            we_d        = 1'b0;
                        end
                        OWN_CPU: begin
                            mem_addr_d  = cpu_addr;
                            mem_wdata_d = cpu_wdata;
                            we_d        = cpu_we;
                        end
                        default: begin
                            mem_addr_d  = mem_addr_q;
                            mem_wdata_d = mem_wdata_q;
                            we_d        = 1'b0;
                        end
                    endcase
                    mem_re_d = ~we_d;
                    mem_we_d = we_d;
                end else if (blk_s) begin
                    // Blocked CPU access: skip the memory, complete in the next cycle.
                    owner_d   = OWN_CPU;
                    we_d      = cpu_we;
                    blk_d     = 1'b1;
                    cpu_ack_d = 1'b1;
                    state_d   = RESP;
                    if (!cpu_we) begin
                        cpu_rdata_d = BLOCKED_RDATA;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Ack is registered here so it is visible during RESP, alongside the read data.
                state_d = RESP;
                case (owner_q)
                    OWN_BG:  bg_ack_d  = 1'b1;
                    OWN_SPR: spr_ack_d = 1'b1;
                    OWN_CPU: cpu_ack_d = 1'b1;
                    default: bg_ack_d  = 1'b0;
                endcase
            end
            RESP: begin
                // Capture the VRAM byte into the owner's holding register.
                state_d = IDLE;
                if (!blk_q) begin
                    case (owner_q)
                        OWN_BG:  bg_rdata_d  = mem_rdata;
                        OWN_SPR: spr_rdata_d = mem_rdata;
                        OWN_CPU: begin
                            if (!we_q) begin
                                cpu_rdata_d = mem_rdata;
                            end else begin
                                cpu_rdata_d = cpu_rdata_q;
                            end
                        end
                        default: bg_rdata_d = bg_rdata_q;
                    endcase
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_BG;
            we_q        <= 1'b0;
            blk_q       <= 1'b0;
            bg_ack_q    <= 1'b0;
            spr_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            bg_rdata_q  <= 8'h00;
            spr_rdata_q <= 8'h00;
            cpu_rdata_q <= 8'h00;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            blk_q       <= blk_d;
            bg_ack_q    <= bg_ack_d;
            spr_ack_q   <= spr_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            bg_rdata_q  <= bg_rdata_d;
            spr_rdata_q <= spr_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // During RESP the VRAM byte is already on mem_rdata, so forward it while ack is high.
    assign bg_rdata  = (state_q == RESP && owner_q == OWN_BG  && !blk_q) ? mem_rdata : bg_rdata_q;
    assign spr_rdata = (state_q == RESP && owner_q == OWN_SPR && !blk_q) ? mem_rdata : spr_rdata_q;
    assign cpu_rdata = (state_q == RESP && owner_q == OWN_CPU && !blk_q && !we_q) ? mem_rdata : cpu_rdata_q;

    assign bg_ack    = bg_ack_q;
    assign spr_ack   = spr_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: table of single-winner vectors plus hand-written
// multi-cycle sequences, checked through ack and strobe scoreboards.
module tb_vram_arbiter;

    localparam logic [12:0] A_BG  = 13'h1800;
    localparam logic [12:0] A_SPR = 13'h1C40;
    localparam logic [12:0] A_CPU = 13'h0010;
    localparam int OWN_BG = 0, OWN_SPR = 1, OWN_CPU = 2, OWN_NONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lcd_on = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        bg_req = 1'b0, spr_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [12:0] bg_addr = A_BG, spr_addr = A_SPR, cpu_addr = A_CPU;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        bg_ack, spr_ack, cpu_ack, mem_re, mem_we;
    logic [7:0]  bg_rdata, spr_rdata, cpu_rdata, mem_wdata;
    logic [12:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  cpu_loc = 8'h11;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .lcd_on(lcd_on), .mode(mode),
        .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_rdata(bg_rdata),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_rdata(spr_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Tiny VRAM model: fixed bytes at the fetcher addresses, one writable CPU byte.
    always @(posedge clk) begin
        if (mem_re) begin
            if (mem_addr == A_BG)       mem_rdata <= 8'h2A;
            else if (mem_addr == A_SPR) mem_rdata <= 8'h3C;
            else if (mem_addr == A_CPU) mem_rdata <= cpu_loc;
            else                        mem_rdata <= 8'h00;
        end
        if (mem_we && mem_addr == A_CPU) cpu_loc <= mem_wdata;
    end

    typedef struct { int own; int cyc; logic [7:0] rd; } ack_exp_t;
    typedef struct { int cyc; logic we; logic [12:0] addr; logic [7:0] wd; } mem_exp_t;
    typedef struct {
        logic lcd; logic [1:0] md; logic bg; logic spr; logic cpu; logic we; logic [7:0] wd;
        int own; int lat; int mk; logic [7:0] rd;
    } vec_t;

    ack_exp_t aq[$];
    mem_exp_t mq[$];
    vec_t     vt[13];
    int       cyc = 0;
    int       n_chk = 0;
    int       n_pass = 0;
    bit       drop_all = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic exp_ack(input int own, input int c, input logic [7:0] rd);
        ack_exp_t e;
        e.own = own; e.cyc = c; e.rd = rd;
        aq.push_back(e);
    endtask

    task automatic exp_mem(input int c, input logic we, input logic [12:0] a, input logic [7:0] wd);
        mem_exp_t e;
        e.cyc = c; e.we = we; e.addr = a; e.wd = wd;
        mq.push_back(e);
    endtask

    task automatic ack_seen(input int own, input logic [7:0] rd);
        ack_exp_t e;
        if (aq.size() == 0) begin
            chk("unexpected_ack", own, OWN_NONE);
        end else begin
            e = aq.pop_front();
            chk("ack_owner", own, e.own);
            chk("ack_cycle", cyc, e.cyc);
            chk("ack_rdata", int'(rd), int'(e.rd));
        end
        if (drop_all) begin
            bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0;
        end else if (own == OWN_BG) bg_req = 1'b0;
        else if (own == OWN_SPR) spr_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    task automatic check_cycle();
        mem_exp_t m;
        chk("re_we_exclusive", int'(mem_re & mem_we), 0);
        if (mem_re || mem_we) begin
            if (mq.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                m = mq.pop_front();
                chk("strobe_cycle", cyc, m.cyc);
                chk("strobe_is_write", int'(mem_we), int'(m.we));
                chk("mem_addr", int'(mem_addr), int'(m.addr));
                if (m.we) chk("mem_wdata", int'(mem_wdata), int'(m.wd));
            end
        end
        if (bg_ack)  ack_seen(OWN_BG, bg_rdata);
        if (spr_ack) ack_seen(OWN_SPR, spr_rdata);
        if (cpu_ack) ack_seen(OWN_CPU, cpu_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && aq.size() > 0; i++) tick();
        chk("ack_timeout", aq.size(), 0);
        chk("strobe_missing", mq.size(), 0);
        aq.delete();
        mq.delete();
        tick();
    endtask

    task automatic apply_vec(input vec_t v);
        int n;
        logic [12:0] a;
        lcd_on = v.lcd; mode = v.md;
        bg_req = v.bg; spr_req = v.spr; cpu_req = v.cpu;
        cpu_we = v.we; cpu_wdata = v.wd;
        n = cyc;
        a = (v.own == OWN_BG) ? A_BG : (v.own == OWN_SPR) ? A_SPR : A_CPU;
        if (v.own == OWN_NONE) begin
            repeat (6) tick();
            bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0;
            tick();
        end else begin
            exp_ack(v.own, n + v.lat, v.rd);
            if (v.mk != 0) exp_mem(n + 1, v.mk == 2, a, v.wd);
            wait_done(12);
        end
    endtask

    initial begin
        int n;
        // lcd, mode, bg, spr, cpu, we, wdata, owner, ack latency, strobe (0 none/1 re/2 we), rdata
        vt[0]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, OWN_BG,   2, 1, 8'h2A};
        vt[1]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, OWN_SPR,  2, 1, 8'h3C};
        vt[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, OWN_CPU,  1, 0, 8'hFF};
        vt[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, OWN_CPU,  1, 0, 8'hFF};
        vt[4]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, OWN_BG,   2, 1, 8'h2A};
        vt[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, OWN_CPU,  2, 1, 8'h11};
        vt[6]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, OWN_CPU,  2, 1, 8'h11};
        vt[7]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, OWN_SPR,  2, 1, 8'h3C};
        vt[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, OWN_CPU,  2, 2, 8'h11};
        vt[9]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, OWN_CPU,  2, 1, 8'hAA};
        vt[10] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, OWN_NONE, 0, 0, 8'h00};
        vt[11] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, OWN_CPU,  2, 1, 8'hAA};
        vt[12] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, OWN_SPR,  2, 1, 8'h3C};

        // Reset state.
        tick(); tick();
        chk("rst_bg_ack", int'(bg_ack), 0);
        chk("rst_spr_ack", int'(spr_ack), 0);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_mem_re", int'(mem_re), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_rdata", int'({bg_rdata, spr_rdata, cpu_rdata}), 0);
        reset = 1'b1;
        tick();

        drop_all = 1'b1;
        for (int i = 0; i < 13; i++) apply_vec(vt[i]);

        drop_all = 1'b0;
        // spr and bg together in mode 3: spr first, bg three cycles later.
        lcd_on = 1'b1; mode = 2'd3; bg_req = 1'b1; spr_req = 1'b1; cpu_req = 1'b0;
        n = cyc;
        exp_mem(n + 1, 1'b0, A_SPR, 8'h00); exp_ack(OWN_SPR, n + 2, 8'h3C);
        exp_mem(n + 4, 1'b0, A_BG, 8'h00);  exp_ack(OWN_BG, n + 5, 8'h2A);
        wait_done(15);

        // mode 0: CPU write 0x55 beats bg; bg served afterwards; cpu_rdata held.
        mode = 2'd0; bg_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'h55;
        n = cyc;
        exp_mem(n + 1, 1'b1, A_CPU, 8'h55); exp_ack(OWN_CPU, n + 2, 8'hAA);
        exp_mem(n + 4, 1'b0, A_BG, 8'h00);  exp_ack(OWN_BG, n + 5, 8'h2A);
        wait_done(15);

        // Mode 3->0 during the bg ACCESS cycle; the queued CPU read then reads back 0x55.
        mode = 2'd3; bg_req = 1'b1; cpu_req = 1'b0;
        n = cyc;
        exp_mem(n + 1, 1'b0, A_BG, 8'h00);  exp_ack(OWN_BG, n + 2, 8'h2A);
        exp_mem(n + 4, 1'b0, A_CPU, 8'h00); exp_ack(OWN_CPU, n + 5, 8'h55);
        tick();
        mode = 2'd0; cpu_req = 1'b1; cpu_we = 1'b0;
        wait_done(15);

        // Requester drops req during ACCESS: the latched access still completes.
        mode = 2'd1; spr_req = 1'b1;
        n = cyc;
        exp_mem(n + 1, 1'b0, A_SPR, 8'h00); exp_ack(OWN_SPR, n + 2, 8'h3C);
        tick();
        spr_req = 1'b0;
        wait_done(10);

        // Reset during ACCESS: no ack, outputs cleared, FSM back in IDLE.
        mode = 2'd0; bg_req = 1'b1;
        n = cyc;
        exp_mem(n + 1, 1'b0, A_BG, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        chk("ra_bg_ack", int'(bg_ack), 0);
        chk("ra_mem_re", int'(mem_re), 0);
        chk("ra_mem_addr", int'(mem_addr), 0);
        chk("ra_bg_rdata", int'(bg_rdata), 0);
        chk("ra_cpu_rdata", int'(cpu_rdata), 0);
        reset = 1'b1;
        n = cyc;
        exp_mem(n + 1, 1'b0, A_BG, 8'h00); exp_ack(OWN_BG, n + 2, 8'h2A);
        wait_done(10);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 13, meaning the VRAM byte address width (0x0000-0x1FFF).
REQ-002 The module SHALL have parameter BLOCKED_RDATA, default 8'hFF, meaning the data returned to a CPU read that is blocked in mode 3.
REQ-003 The module SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic on posedge.
  reset  in  1  synchronous, active-low reset.
  lcd_on  in  1  LCDC.7.
  mode  in  2  PPU mode; 2'd3 = pixel transfer.
  bg_req / spr_req  in  1  BG fetcher / sprite fetcher read request (level).
  bg_addr / spr_addr  in  ADDR_W  read address.
  bg_ack / spr_ack  out  1  one-cycle completion pulse.
  bg_rdata / spr_rdata  out  8  read data, valid while the matching ack is high.
  cpu_req  in  1  CPU access request (level).
  cpu_we  in  1  1 = write, 0 = read.
  cpu_addr  in  ADDR_W  CPU address.
  cpu_wdata  in  8  CPU write data.
  cpu_ack  out  1  one-cycle completion pulse.
  cpu_rdata  out  8  CPU read data, valid with cpu_ack.
  mem_re / mem_we  out  1  VRAM read / write strobe.
  mem_addr  out  ADDR_W  VRAM address.
  mem_wdata  out  8  VRAM write data.
  mem_rdata  in  8  VRAM read data, valid one cycle after mem_re.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and RESP; at most one access SHALL be in flight.
REQ-005 In IDLE the module SHALL sample all requests, select one winner, latch its owner, address, we and wdata, and move to ACCESS.
REQ-006 If mode==3 and lcd_on==1, the priority SHALL be spr > bg, and the CPU SHALL NOT be granted.
REQ-007 Otherwise, with lcd_on==1, the priority SHALL be cpu > spr > bg.
REQ-008 If lcd_on==0, bg_req and spr_req SHALL be ignored (never acked), and the CPU SHALL be granted.
REQ-009 In ACCESS the module SHALL assert exactly one of mem_re or mem_we for exactly one cycle, drive mem_addr and mem_wdata from the latched values, and move to RESP.
REQ-010 In RESP the module SHALL register mem_rdata into the owner's rdata output, pulse the owner's ack for one cycle, and return to IDLE.
REQ-011 A granted access SHALL therefore be acked in cycle N+2 when req is sampled in IDLE at cycle N; sustained throughput SHALL be one access per 3 cycles.
REQ-012 A CPU write SHALL pulse cpu_ack in RESP, and cpu_rdata SHALL hold its previous value.
REQ-013 If cpu_req is high in IDLE while mode==3 and lcd_on==1, and no PPU request is pending, the module SHALL take a blocked completion: no mem strobe, cpu_ack pulsed the next cycle, cpu_rdata=BLOCKED_RDATA for reads, and writes dropped. FSM: IDLE->RESP.
REQ-014 A blocked CPU access SHALL NOT preempt a pending PPU request; a PPU request in the same IDLE cycle SHALL win.
REQ-015 A mode or lcd_on change while in ACCESS or RESP SHALL NOT abort the in-flight access; it SHALL complete with the latched owner.
REQ-016 Requesters SHALL hold req, addr and wdata stable until ack. A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-017 A request that loses arbitration SHALL remain pending with no ack; there is no timeout.
REQ-018 mem_re, mem_we and all ack outputs SHALL be 0 outside the cycles specified above. mem_re and mem_we SHALL never be high together.
REQ-019 A requester deasserting req before ack SHALL NOT cancel an access already latched.

Reset
REQ-020 While reset==0 at a clk edge: state<=IDLE; all acks, mem_re and mem_we <=0; mem_addr, mem_wdata and all rdata outputs <=0.
REQ-021 Reset asserted in ACCESS or RESP SHALL drop the in-flight access: no ack, and no strobe on the following cycle.

Verification
REQ-022 The bench SHALL cover: mode=3, bg_req with bg_addr=0x1800, mem_rdata=0x2A -> mem_re at N+1 with mem_addr=0x1800, and bg_ack with bg_rdata=0x2A at N+2.
REQ-023 The bench SHALL cover: mode=3, bg_req and spr_req raised in the same cycle -> spr served first (spr_ack at N+2); bg_ack at N+5 if bg_req is held.
REQ-024 The bench SHALL cover: mode=3, CPU read alone -> no mem_re, cpu_ack at N+1, cpu_rdata=0xFF; CPU write 0x55 to 0x0010 -> cpu_ack pulsed, mem_we never asserted.
REQ-025 The bench SHALL cover: mode=0, cpu write 0x55 to 0x0010 and bg_req together -> mem_we at N+1 with addr 0x0010 and wdata 0x55, cpu_ack at N+2, then bg serviced.
REQ-026 The bench SHALL cover: mode switches 3->0 during ACCESS of a bg read -> bg_ack still at N+2 with the correct data.
REQ-027 The bench SHALL cover: reset=0 during ACCESS -> no ack; all outputs 0 after the edge; FSM in IDLE.
